// File: rtl/rx_decimator_acc.sv
// Multi-channel rx sample decimator: pick (keep 1 of N) or accumulate-and-dump (sum of N).
// Ratio and mode are latched at each group start; the output strobe lags its qualifying trigger by one clock.
module rx_decimator_acc #(
    parameter int DATA_W         = 16,
    parameter int CHANNELS       = 2,
    parameter int MAX_DECIMATION = 16,
    localparam int RW            = $clog2(MAX_DECIMATION) + 1,
    localparam int ACC_W         = DATA_W + $clog2(MAX_DECIMATION)
) (
    input  logic                      crx_clk,
    input  logic                      rrx_rst_n,
    input  logic                      erx_en,
    input  logic [RW-1:0]             idecimation,
    input  logic                      imode,
    input  logic                      inew_sample_trigg,
    input  logic [CHANNELS*DATA_W-1:0] isample_data,
    output logic                      onew_sample_trigg,
    output logic [CHANNELS*ACC_W-1:0] osample_data,
    output logic                      oconfig_err
);

    localparam logic [RW-1:0] MAX_D = RW'(MAX_DECIMATION);

    logic [RW-1:0]             r_count;
    logic [RW-1:0]             r_nlat;
    logic                      r_mode;
    logic                      r_valid;
    logic                      r_err;
    logic [CHANNELS*ACC_W-1:0] r_data;
    logic signed [ACC_W-1:0]   r_acc [CHANNELS];

    logic                      w_start;
    logic                      w_dec_illegal;
    logic [RW-1:0]             w_n_req;
    logic [RW-1:0]             w_n_eff;
    logic                      w_mode_eff;
    logic                      w_last;
    logic signed [DATA_W-1:0]  w_samp [CHANNELS];
    logic signed [ACC_W-1:0]   w_sext [CHANNELS];
    logic signed [ACC_W-1:0]   w_sum  [CHANNELS];

    // At a group start the freshly requested ratio/mode already govern the current sample.
    always_comb begin
        w_start       = (r_count == '0);
        w_dec_illegal = (idecimation == '0) || (idecimation > MAX_D);
        if (idecimation == '0)
            w_n_req = RW'(1);
        else if (idecimation > MAX_D)
            w_n_req = MAX_D;
        else
            w_n_req = idecimation;
        w_n_eff    = w_start ? w_n_req : r_nlat;
        w_mode_eff = w_start ? imode : r_mode;
        w_last     = (r_count == (w_n_eff - 1'b1));
        for (int c = 0; c < CHANNELS; c++) begin
            w_samp[c] = isample_data[c*DATA_W +: DATA_W];
            w_sext[c] = ACC_W'(w_samp[c]);
            w_sum[c]  = w_start ? w_sext[c] : (r_acc[c] + w_sext[c]);
        end
    end

    always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
        if (!rrx_rst_n) begin
            r_count <= '0;
            r_nlat  <= '0;
            r_mode  <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_data  <= '0;
            for (int c = 0; c < CHANNELS; c++)
                r_acc[c] <= '0;
        end else begin
            r_valid <= 1'b0;
            if (!erx_en) begin
                r_count <= '0;
                for (int c = 0; c < CHANNELS; c++)
                    r_acc[c] <= '0;
            end else if (inew_sample_trigg) begin
                if (w_start) begin
                    r_nlat <= w_n_req;
                    r_mode <= imode;
                    if (w_dec_illegal)
                        r_err <= 1'b1;
                end
                r_count <= w_last ? '0 : (r_count + 1'b1);
                for (int c = 0; c < CHANNELS; c++)
                    r_acc[c] <= w_sum[c];
                if (!w_mode_eff && w_start) begin
                    r_valid <= 1'b1;
                    for (int c = 0; c < CHANNELS; c++)
                        r_data[c*ACC_W +: ACC_W] <= w_sext[c];
                end else if (w_mode_eff && w_last) begin
                    r_valid <= 1'b1;
                    for (int c = 0; c < CHANNELS; c++)
                        r_data[c*ACC_W +: ACC_W] <= w_sum[c];
                end
            end
        end
    end

    assign onew_sample_trigg = r_valid;
    assign osample_data      = r_data;
    assign oconfig_err       = r_err;

endmodule

// File: doc/rx_decimator_acc.md
Name: rx_decimator_acc

Overview:
Parametrised, multi-channel sample decimator for the rx chain. It replaces the trigger-only decimator. It carries sample data and has a run-time decimation ratio. Two modes: pick (keep 1 of N samples) and accumulate-and-dump (sum N samples, boxcar pre-filter). It sits between the rx filter output and downstream correlator/detector logic, and runs on the shared rx sample-trigger strobe.

Parameters:
DATA_W, 16, signed sample width per channel
CHANNELS, 2, number of parallel channels sharing one trigger
MAX_DECIMATION, 16, largest legal ratio (>=1)
Derived (localparam): RW = $clog2(MAX_DECIMATION)+1; ACC_W = DATA_W + $clog2(MAX_DECIMATION)

Ports:
crx_clk  in  1  rx clock; all logic on rising edge
rrx_rst_n  in  1  asynchronous, active-low reset
erx_en  in  1  block enable
idecimation  in  RW  requested ratio N (unsigned)
imode  in  1  0 = pick, 1 = accumulate
inew_sample_trigg  in  1  one-cycle strobe; isample_data valid this cycle
isample_data  in  CHANNELS*DATA_W  channel c at bits [c*DATA_W +: DATA_W], signed
onew_sample_trigg  out  1  one-cycle strobe; osample_data valid this cycle
osample_data  out  CHANNELS*ACC_W  channel c at bits [c*ACC_W +: ACC_W], signed
oconfig_err  out  1  sticky flag: an illegal ratio was latched

Behaviour:
- Reset (rrx_rst_n=0, asynchronous): counter, accumulators, latched ratio/mode, onew_sample_trigg, osample_data and oconfig_err all go to 0 immediately. Reset can hit mid-group; the partial group is lost.
- Group counter rcount runs 0..Nlat-1. It advances only on inew_sample_trigg while erx_en=1, and wraps to 0 after Nlat-1.
- Ratio/mode latch: idecimation and imode are sampled only on a trigger with rcount=0 (group start). That sample belongs to the new group. Changes at any other time take effect at the next group start.
- Illegal ratio: idecimation=0 latches Nlat=1; idecimation>MAX_DECIMATION latches MAX_DECIMATION. Either case sets oconfig_err, which clears only on reset.
- Pick mode: on a trigger with rcount=0, the next cycle gives onew_sample_trigg=1 and osample_data = the sign-extended input samples. No other triggers in the group produce output.
- Accumulate mode, per channel:
  - trigger with rcount=0: acc <= sign-extended sample (load, not add).
  - other triggers: acc <= acc + sample.
  - trigger with rcount=Nlat-1: the next cycle gives onew_sample_trigg=1 and osample_data = final sum (acc + current sample).
  - ACC_W cannot overflow for N<=MAX_DECIMATION. No scaling or rounding.
- Nlat=1: every trigger produces output one cycle later in both modes. The pick and accumulate values are identical.
- Latency: exactly 1 crx_clk from the qualifying input trigger to onew_sample_trigg. Back-to-back triggers (every cycle) are supported at full rate.
- osample_data holds its last value between strobes.
- erx_en=0:
  - rcount and accumulators are cleared synchronously and triggers are ignored.
  - onew_sample_trigg is 0, except that a strobe already registered from the previous cycle still appears.
  - A partial group is discarded; the next enabled trigger starts a new group and re-latches ratio/mode.
- Trigger with erx_en rising in the same cycle: the trigger counts as a group start.

Test Plan:
1. Pick, N=4, triggers every 3 cycles, samples 1..8 -> two strobes, data 1 then 5, each 1 cycle after the trigger of sample 1/5.
2. Accumulate, N=4, DATA_W=16, all samples 0x7FFF on ch0 and 0x8000 on ch1 -> ch0 = 0x1FFFC and ch1 = -131072 (0xE0000) in ACC_W=20; strobe 1 cycle after the 4th trigger.
3. Ratio change mid-group: N=4, set idecimation=2 after sample 2 -> the first group still sums 4 samples; subsequent groups sum 2.
4. idecimation=0 in accumulate mode with samples 3, -7 -> outputs 3, -7 on each trigger; oconfig_err=1 and stays 1 until reset.
5. erx_en dropped after 2 of 4 samples, re-enabled, samples 10,20,30,40 -> single output 100; partial sum absent.
6. Reset asserted asynchronously mid-cycle during a group -> all outputs 0 before the next clock edge. After release, the first trigger starts a fresh group.
